pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/pll_lock_sequencer_if.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 135 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } seq_state_e;

  // Width of the shared down-counter; max+1 keeps an exact power of two loadable.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Host-side bundle of the PLL sequencer lock input, relock request and status outputs.
interface pll_lock_sequencer_if;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;

  modport master (
    input  pll_lock, relock_req,
    output pll_reset, sys_reset, ready, fail, retry_count
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_reset, sys_reset, ready, fail, retry_count
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up a PLL: pulses its reset, waits for a stable lock, then releases the system
// reset; retries on timeout and parks in FAIL after MAX_RETRIES failed attempts.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 27,
  parameter int unsigned LOCK_TIMEOUT    = 27000,
  parameter int unsigned LOCK_STABLE     = 270,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_count
);
  localparam int unsigned CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [CW-1:0] CNT_HOLD    = CW'(RST_HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_TIMEOUT = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_STABLE  = CW'(LOCK_STABLE);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  logic          lock_s;
  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic          pll_reset_q, sys_reset_q, ready_q, fail_q;
  logic          last;
  logic [1:0]    retry_inc;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  // cnt reaching 1 marks the final cycle of the current phase.
  assign last      = (cnt_q == CNT_ONE);
  assign retry_inc = retry_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (relock_req) begin
      state_d = ST_RST_HOLD;
      cnt_d   = CNT_HOLD;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        ST_RST_HOLD: begin
          if (last) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_TIMEOUT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = CNT_STABLE;
          end else if (last) begin
            retry_d = retry_inc;
            if (retry_inc == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RST_HOLD;
              cnt_d   = CNT_HOLD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_TIMEOUT;
          end else if (last) begin
            state_d = ST_RUN;
            retry_d = 2'd0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RST_HOLD;
            cnt_d   = CNT_HOLD;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RST_HOLD;
          cnt_d   = CNT_HOLD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_HOLD;
      cnt_q       <= CNT_HOLD;
      retry_q     <= 2'd0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == ST_RST_HOLD) || (state_d == ST_FAIL);
      sys_reset_q <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus randomized lock waveforms
// compared against a timeline model of the bring-up rules.
module tb_pll_lock_sequencer;
  localparam int RH   = 4;
  localparam int LT   = 20;
  localparam int LS   = 8;
  localparam int MR   = 2;
  localparam int NMAX = 160;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES (RH),
    .LOCK_TIMEOUT    (LT),
    .LOCK_STABLE     (LS),
    .MAX_RETRIES     (MR)
  ) dut (
    .clkin       (clk),
    .reset       (reset),
    .pll_lock    (bus.pll_lock),
    .relock_req  (bus.relock_req),
    .pll_reset   (bus.pll_reset),
    .sys_reset   (bus.sys_reset),
    .ready       (bus.ready),
    .fail        (bus.fail),
    .retry_count (bus.retry_count)
  );

  always #5 clk = ~clk;

  // pl[k]/rl[k]: input values seen by edge k after reset release.
  // obs/expv[k]: {pll_reset, sys_reset, ready, fail, retry_count} just after edge k.
  bit         pl   [0:NMAX];
  bit         rl   [0:NMAX];
  logic [5:0] obs  [0:NMAX];
  logic [5:0] expv [0:NMAX];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [5:0] outs();
    return {bus.pll_reset, bus.sys_reset, bus.ready, bus.fail, bus.retry_count};
  endfunction

  task automatic clear_stim();
    for (int k = 0; k <= NMAX; k++) begin
      pl[k] = 1'b0;
      rl[k] = 1'b0;
    end
  endtask

  task automatic run_trace(input int n);
    @(negedge clk);
    reset = 1'b1;
    bus.pll_lock = 1'b0;
    bus.relock_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 obs[0] = outs();
    for (int k = 1; k <= n; k++) begin
      bus.pll_lock = pl[k];
      bus.relock_req = rl[k];
      @(posedge clk);
      #1 obs[k] = outs();
      @(negedge clk);
    end
    bus.relock_req = 1'b0;
  endtask

  // Lock as seen by the sequencer: two synchronizer cycles behind the pin.
  function automatic bit seen(input int k);
    if (k < 3 || k - 2 > NMAX) return 1'b0;
    return pl[k-2];
  endfunction

  task automatic fill(input int a, input int b, input logic [5:0] v);
    for (int k = a; k <= b; k++)
      if (k >= 0 && k <= NMAX) expv[k] = v;
  endtask

  // Walks the timeline attempt by attempt, searching the lock history for the events
  // that end each phase (no relock requests).
  task automatic build_model();
    int t, w, s, j, r, retries;
    bit done, over;
    retries = 0;
    t = 0;
    done = 1'b0;
    while (!done && t <= NMAX) begin
      fill(t, t + RH - 1, {4'b1100, 2'(retries)});
      w = t + RH;
      over = 1'b0;
      while (!over) begin
        if (w > NMAX) begin
          over = 1'b1;
          done = 1'b1;
        end else begin
          s = -1;
          for (int k = w + 1; k <= w + LT; k++)
            if (seen(k)) begin s = k; break; end
          if (s < 0) begin
            fill(w, w + LT - 1, {4'b0100, 2'(retries)});
            retries++;
            if (retries == MR) begin
              fill(w + LT, NMAX, {4'b1101, 2'(retries)});
              done = 1'b1;
            end else begin
              t = w + LT;
            end
            over = 1'b1;
          end else begin
            fill(w, s - 1, {4'b0100, 2'(retries)});
            j = -1;
            for (int k = s + 1; k <= s + LS; k++)
              if (!seen(k)) begin j = k; break; end
            if (j >= 0) begin
              fill(s, j - 1, {4'b0100, 2'(retries)});
              w = j;
            end else begin
              r = s + LS;
              fill(s, r - 1, {4'b0100, 2'(retries)});
              retries = 0;
              j = r + 1;
              while (j <= NMAX && seen(j)) j++;
              fill(r, j - 1, 6'b001000);
              t = j;
              over = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] cur;
    @(negedge clk);
    reset = 1'b1;
    bus.pll_lock = 1'b1;
    bus.relock_req = 1'b0;
    #1 cur = outs();
    n_cmp++;
    if (cur !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_values got=%b want=%b", cur, 6'b110000);
    end
    @(posedge clk);
    #1 cur = outs();
    n_cmp++;
    if (cur !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_held got=%b want=%b", cur, 6'b110000);
    end
  endtask

  task automatic test_lock_nominal();
    clear_stim();
    for (int k = 15; k <= NMAX; k++) pl[k] = 1'b1;
    run_trace(40);
    build_model();
    for (int k = 0; k <= 40; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_bad++;
        $display("FAIL nominal_trace k=%0d got=%b want=%b", k, obs[k], expv[k]);
      end
    end
    n_cmp++;
    if (obs[3] !== 6'b110000 || obs[4] !== 6'b010000) begin
      n_bad++;
      $display("FAIL nominal_hold got=%b,%b want=110000,010000", obs[3], obs[4]);
    end
    n_cmp++;
    if (obs[24] !== 6'b010000 || obs[25] !== 6'b001000) begin
      n_bad++;
      $display("FAIL nominal_ready_at_25 got=%b,%b want=010000,001000", obs[24], obs[25]);
    end
  endtask

  task automatic test_timeout_fail();
    clear_stim();
    run_trace(60);
    build_model();
    for (int k = 0; k <= 60; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_bad++;
        $display("FAIL timeout_trace k=%0d got=%b want=%b", k, obs[k], expv[k]);
      end
    end
    n_cmp++;
    if (obs[24] !== 6'b110001 || obs[47] !== 6'b010001) begin
      n_bad++;
      $display("FAIL timeout_first got=%b,%b want=110001,010001", obs[24], obs[47]);
    end
    n_cmp++;
    if (obs[48] !== 6'b110110 || obs[60] !== 6'b110110) begin
      n_bad++;
      $display("FAIL timeout_fail got=%b,%b want=110110,110110", obs[48], obs[60]);
    end
  endtask

  task automatic test_glitch_stable();
    clear_stim();
    for (int k = 30; k <= NMAX; k++) pl[k] = 1'b1;
    pl[35] = 1'b0;
    run_trace(60);
    build_model();
    for (int k = 0; k <= 60; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_bad++;
        $display("FAIL glitch_trace k=%0d got=%b want=%b", k, obs[k], expv[k]);
      end
    end
    n_cmp++;
    if (obs[40] !== 6'b010001 || obs[45] !== 6'b010001) begin
      n_bad++;
      $display("FAIL glitch_window got=%b,%b want=010001,010001", obs[40], obs[45]);
    end
    n_cmp++;
    if (obs[46] !== 6'b001000) begin
      n_bad++;
      $display("FAIL glitch_ready got=%b want=001000", obs[46]);
    end
  endtask

  task automatic test_lock_loss_run();
    clear_stim();
    for (int k = 15; k <= NMAX; k++) pl[k] = 1'b1;
    for (int k = 30; k <= 40; k++) pl[k] = 1'b0;
    run_trace(60);
    build_model();
    for (int k = 0; k <= 60; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_bad++;
        $display("FAIL loss_trace k=%0d got=%b want=%b", k, obs[k], expv[k]);
      end
    end
    n_cmp++;
    if (obs[31] !== 6'b001000 || obs[32] !== 6'b110000) begin
      n_bad++;
      $display("FAIL loss_sys_reset got=%b,%b want=001000,110000", obs[31], obs[32]);
    end
    n_cmp++;
    if (obs[35] !== 6'b110000 || obs[36] !== 6'b010000) begin
      n_bad++;
      $display("FAIL loss_pll_hold got=%b,%b want=110000,010000", obs[35], obs[36]);
    end
  endtask

  task automatic test_relock();
    clear_stim();
    rl[24] = 1'b1;
    rl[76] = 1'b1;
    run_trace(80);
    n_cmp++;
    if (obs[24] !== 6'b110000 || obs[28] !== 6'b010000) begin
      n_bad++;
      $display("FAIL relock_at_timeout got=%b,%b want=110000,010000", obs[24], obs[28]);
    end
    n_cmp++;
    if (obs[48] !== 6'b110001) begin
      n_bad++;
      $display("FAIL relock_retry_restart got=%b want=110001", obs[48]);
    end
    n_cmp++;
    if (obs[72] !== 6'b110110 || obs[75] !== 6'b110110) begin
      n_bad++;
      $display("FAIL relock_fail_reached got=%b,%b want=110110,110110", obs[72], obs[75]);
    end
    n_cmp++;
    if (obs[76] !== 6'b110000 || obs[79] !== 6'b110000 || obs[80] !== 6'b010000) begin
      n_bad++;
      $display("FAIL relock_from_fail got=%b,%b,%b want=110000,110000,010000",
               obs[76], obs[79], obs[80]);
    end
  endtask

  task automatic test_reset_mid_stable();
    logic [5:0] cur;
    clear_stim();
    for (int k = 30; k <= NMAX; k++) pl[k] = 1'b1;
    run_trace(36);
    n_cmp++;
    if (obs[36] !== 6'b010001) begin
      n_bad++;
      $display("FAIL midstable_before got=%b want=010001", obs[36]);
    end
    #2 reset = 1'b1;
    #1 cur = outs();
    n_cmp++;
    if (cur !== 6'b110000) begin
      n_bad++;
      $display("FAIL midstable_async_reset got=%b want=110000", cur);
    end
    clear_stim();
    for (int k = 0; k <= NMAX; k++) pl[k] = 1'b1;
    run_trace(16);
    n_cmp++;
    if (obs[3] !== 6'b110000 || obs[4] !== 6'b010000) begin
      n_bad++;
      $display("FAIL restart_hold got=%b,%b want=110000,010000", obs[3], obs[4]);
    end
    n_cmp++;
    if (obs[12] !== 6'b010000 || obs[13] !== 6'b001000) begin
      n_bad++;
      $display("FAIL restart_ready got=%b,%b want=010000,001000", obs[12], obs[13]);
    end
  endtask

  task automatic test_random();
    int k, len;
    bit lvl;
    for (int it = 0; it < 6; it++) begin
      clear_stim();
      lvl = 1'b0;
      k = 1;
      while (k <= NMAX) begin
        len = $urandom_range(30, 1);
        for (int i = 0; i < len && k <= NMAX; i++) begin
          pl[k] = lvl;
          k++;
        end
        lvl = ~lvl;
      end
      run_trace(150);
      build_model();
      for (int c = 0; c <= 150; c++) begin
        n_cmp++;
        if (obs[c] !== expv[c]) begin
          n_bad++;
          $display("FAIL random_trace it=%0d k=%0d got=%b want=%b", it, c, obs[c], expv[c]);
        end
      end
    end
  endtask

  initial begin
    bus.pll_lock = 1'b0;
    bus.relock_req = 1'b0;
    test_reset();
    test_lock_nominal();
    test_timeout_fail();
    test_glitch_stable();
    test_lock_loss_run();
    test_relock();
    test_reset_mid_stable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
